// File: rtl/count_seq_monitor.sv
// Monitors a 2-bit modulo-4 count stream: syncs, locks, then counts wraps and sequence errors.
// Optional macro SEQ_MON_HOLD_TOLERATE_EN treats a repeated sample as a stall instead of an error.
module count_seq_monitor #(
    parameter int unsigned SYNC_LEN = 3,
    parameter int unsigned WRAP_W   = 8,
    parameter int unsigned ERR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cnt_in,
    input  logic              cnt_valid,
    input  logic              clear,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_count,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        TRACK = 2'b10,
        ERROR = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        prev_q, prev_d;
    logic [3:0]        sync_cnt_q, sync_cnt_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

    logic [1:0] expected;
    logic [3:0] sync_nxt;
    logic       match;
    logic       hold;

    assign expected = prev_q + 2'd1;
    assign match    = (cnt_in == expected);
    assign sync_nxt = sync_cnt_q + 4'd1;

`ifdef SEQ_MON_HOLD_TOLERATE_EN
    assign hold = (cnt_in == prev_q);
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        sync_cnt_d   = sync_cnt_q;
        locked_d     = locked_q;
        err_d        = err_q;
        err_count_d  = err_count_q;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;

        // clear wins over the sample on the same edge
        if (clear) begin
            state_d      = IDLE;
            prev_d       = 2'd0;
            sync_cnt_d   = 4'd0;
            locked_d     = 1'b0;
            err_d        = 1'b0;
            err_count_d  = '0;
            wrap_count_d = '0;
        end else if (cnt_valid) begin
            unique case (state_q)
                IDLE, ERROR: begin
                    prev_d     = cnt_in;
                    sync_cnt_d = 4'd0;
                    state_d    = SYNC;
                end
                SYNC: begin
                    prev_d = cnt_in;
                    if (match) begin
                        sync_cnt_d = sync_nxt;
                        if (sync_nxt == 4'(SYNC_LEN)) begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                        end
                    end else if (!hold) begin
                        sync_cnt_d = 4'd0;
                    end
                end
                TRACK: begin
                    if (match) begin
                        prev_d = cnt_in;
                        if (prev_q == 2'd3) begin
                            wrap_pulse_d = 1'b1;
                            wrap_count_d = wrap_count_q + WRAP_W'(1);
                        end
                    end else if (!hold) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        prev_d   = cnt_in;
                        state_d  = ERROR;
                        if (err_count_q != '1)
                            err_count_d = err_count_q + ERR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= 2'd0;
            sync_cnt_q   <= 4'd0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            sync_cnt_q   <= sync_cnt_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor; set SEQ_MON_HOLD_TOLERATE_EN to match the RTL build.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cnt_in;
    logic       cnt_valid;
    logic       clear;
    logic       locked;
    logic       err;
    logic [3:0] err_count;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic [1:0] state_out;

    int checks   = 0;
    int failures = 0;

    count_seq_monitor #(.SYNC_LEN(3), .WRAP_W(8), .ERR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .cnt_valid  (cnt_valid),
        .clear      (clear),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic e, input logic [3:0] ec,
                           input logic wp, input logic [7:0] wc, input logic [1:0] st);
        chk({tag, ".locked"},     32'(locked),     32'(l));
        chk({tag, ".err"},        32'(err),        32'(e));
        chk({tag, ".err_count"},  32'(err_count),  32'(ec));
        chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
        chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(wc));
        chk({tag, ".state_out"},  32'(state_out),  32'(st));
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic v, input logic [1:0] d, input logic c = 1'b0);
        @(negedge clk);
        cnt_valid = v;
        cnt_in    = d;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cnt_in = 2'd0; cnt_valid = 1'b0; clear = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        reset = 1'b0;

        // 1: sync and lock
        step(1, 0); chk_all("t1_s0", 0, 0, 0, 0, 0, 2'b01);
        step(1, 1); chk("t1_s1.state", 32'(state_out), 32'h1);
        step(1, 2); chk("t1_s2.locked", 32'(locked), 32'h0);
        step(1, 3); chk_all("t1_lock", 1, 0, 0, 0, 0, 2'b10);

        // 2: wraps in TRACK
        step(1, 0); chk_all("t2_wrap1", 1, 0, 0, 1, 1, 2'b10);
        step(0, 2); chk_all("t2_idle", 1, 0, 0, 0, 1, 2'b10);
        step(1, 1); chk("t2_s1.wp", 32'(wrap_pulse), 32'h0);
        step(1, 2); chk("t2_s2.wp", 32'(wrap_pulse), 32'h0);
        step(1, 3); chk("t2_s3.wp", 32'(wrap_pulse), 32'h0);
        step(1, 0); chk_all("t2_wrap2", 1, 0, 0, 1, 2, 2'b10);
        step(1, 1); chk("t2_after.wp", 32'(wrap_pulse), 32'h0);

        // 3: error at prev=1, then re-sync
        step(1, 3); chk_all("t3_err", 0, 1, 1, 0, 2, 2'b11);
        step(1, 0); chk_all("t3_sync", 0, 1, 1, 0, 2, 2'b01);
        step(1, 1);
        step(1, 2); chk("t3_pre.locked", 32'(locked), 32'h0);
        step(1, 3); chk_all("t3_relock", 1, 1, 1, 0, 2, 2'b10);

        // 4: drive err_count to saturation (16 errors total)
        for (int i = 0; i < 15; i++) begin
            step(1, 1);
            chk($sformatf("t4_err%0d.ec", i), 32'(err_count), (i + 2 > 15) ? 32'd15 : 32'(i + 2));
            step(1, 0); step(1, 1); step(1, 2); step(1, 3);
        end
        chk_all("t4_sat", 1, 1, 15, 0, 2, 2'b10);
        step(1, 1, 1'b1); chk_all("t4_clear", 0, 0, 0, 0, 0, 2'b00);
        step(1, 2); chk_all("t4_post", 0, 0, 0, 0, 0, 2'b01);
        step(1, 3); step(1, 0);
        step(1, 1); chk_all("t4_lock", 1, 0, 0, 0, 0, 2'b10);

        // 5: valid low holds everything
        for (int i = 0; i < 5; i++) begin
            step(0, 2'($urandom_range(0, 3)));
            chk_all($sformatf("t5_hold%0d", i), 1, 0, 0, 0, 0, 2'b10);
        end
        step(1, 2); chk_all("t5_resume", 1, 0, 0, 0, 0, 2'b10);

        // 6: repeated value at prev=2
        step(1, 2);
`ifdef SEQ_MON_HOLD_TOLERATE_EN
        chk_all("t6_stall", 1, 0, 0, 0, 0, 2'b10);
        step(1, 3); chk_all("t6_next", 1, 0, 0, 0, 0, 2'b10);
`else
        chk_all("t6_repeat", 0, 1, 1, 0, 0, 2'b11);
        step(1, 3); chk_all("t6_next", 0, 1, 1, 0, 0, 2'b01);
`endif

        // async reset between edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 2'b00);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
Downstream consumer of the 2-bit FSM binary counter output. Samples the count stream, checks that each sample is the modulo-4 increment of the previous one, and locks onto it after a sync period. Counts wrap events (3->0) and sequence errors, and exposes lock/error status for the debug and status logic.

Parameters:
SYNC_LEN, 3, consecutive correct increments required in SYNC before lock (legal range 1..15)
WRAP_W, 8, width of wrap_count
ERR_W, 4, width of err_count

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
cnt_in  input  2  count value from upstream counter
cnt_valid  input  1  cnt_in is sampled on this edge; when low, all state holds
clear  input  1  synchronous clear of status and counters
locked  output  1  high while in TRACK
err  output  1  sticky error flag
err_count  output  ERR_W  number of errors detected in TRACK, saturating
wrap_pulse  output  1  single-cycle pulse on an accepted 3->0 transition in TRACK
wrap_count  output  WRAP_W  number of wraps accepted in TRACK, rolls over modulo 2^WRAP_W
state_out  output  2  current FSM state encoding

Behaviour:
- Reset (async, active-high): state=IDLE, prev=0, sync_cnt=0; locked=0, err=0, err_count=0, wrap_pulse=0, wrap_count=0, state_out=2'b00.
- All outputs registered. A sample taken at edge N is reflected on the outputs immediately after edge N (1-cycle latency from cnt_in to output).
- "Expected" = (prev + 1) mod 4 (2-bit add, carry dropped).
- States (state_out encoding):
  IDLE (00): on cnt_valid -> prev<=cnt_in, sync_cnt<=0, go SYNC.
  SYNC (01): on cnt_valid: if cnt_in==expected -> sync_cnt++; when the incremented value reaches SYNC_LEN, go TRACK, set locked=1. If cnt_in!=expected -> sync_cnt<=0 and stay in SYNC. No error is recorded. prev<=cnt_in in both cases.
  TRACK (10): on cnt_valid: if cnt_in==expected -> prev<=cnt_in; if prev==3 and cnt_in==0 -> wrap_pulse=1 for one cycle, wrap_count++. If cnt_in!=expected -> err<=1, err_count++ (saturates at all-ones), locked<=0, prev<=cnt_in, go ERROR.
  ERROR (11): on cnt_valid -> prev<=cnt_in, sync_cnt<=0, go SYNC. No further error counting until TRACK is re-entered.
- cnt_valid low: no check, no state change, wrap_pulse=0.
- wrap_pulse is 0 in every cycle other than the one following an accepted wrap. A wrap seen in SYNC is not counted.
- clear (synchronous, higher priority than cnt_valid): state=IDLE and all outputs return to reset values. The sample on that edge is dropped.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.
- err stays set until clear or reset.

Optional Feature:
SEQ_MON_HOLD_TOLERATE_EN
- Defined: in TRACK, a sample with cnt_in==prev is treated as a stall. It is accepted, causes no error, and does not change state. In SYNC it leaves sync_cnt unchanged instead of resetting it.
- Undefined: a repeated value is a mismatch and follows the normal error rules above.

Test Plan:
1. Reset, then cnt_valid=1 with stream 0,1,2,3 -> SYNC entered after 0. locked=1 after sample 3 (SYNC_LEN=3). state_out=10. err=0.
2. Locked, continue 0,1,2,3,0 -> wrap_pulse high exactly one cycle after each 3->0 sample. wrap_count=2. No pulse on other samples.
3. Locked at prev=1, inject 3 -> err=1, err_count=1, locked=0, state_out=11. Next valid 0 -> SYNC. Then 1,2,3 -> locked=1, err remains 1.
4. Run 16 induced errors with ERR_W=4 -> err_count saturates at 15. Assert clear with cnt_valid=1 -> state IDLE, all outputs 0, sample dropped.
5. Locked, hold cnt_valid=0 for 5 cycles while cnt_in toggles randomly -> no change in any output. Resume with the expected value -> no error.
6. Locked at prev=2, repeat 2 -> without macro: err=1, state ERROR. With SEQ_MON_HOLD_TOLERATE_EN: err=0, locked=1, and the following 3 is accepted.
